// File: rtl/sample_dac_spi.sv
// Sample-path sink: converts a signed 12-bit sample to offset binary and
// sends it as a 16-bit SPI mode-0 frame to an MCP4921-class DAC, then pulses LDAC.
module sample_dac_spi #(
    parameter int   CLK_DIV    = 4,
    parameter logic CFG_BUF    = 1'b0,
    parameter logic CFG_GA_N   = 1'b1,
    parameter logic CFG_SHDN_N = 1'b1
) (
    input  logic        inCLK,
    input  logic        inRST_N,
    input  logic [11:0] inSample,
    input  logic        inSampleStrobe,
    output logic        outBusy,
    output logic        outDone,
    output logic        outOverrun,
    output logic        outCS_n,
    output logic        outSCK,
    output logic        outSDI,
    output logic        outLDAC_n,
    output logic [2:0]  outDbgState
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        CS_END   = 3'd4,
        LDAC     = 3'd5
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic [7:0]  r_div;
    logic [4:0]  r_bits;
    logic [15:0] r_shift;
    logic        r_done;
    logic        r_overrun;
    logic        r_busy;
    logic        r_cs_n;
    logic        r_sck;
    logic        r_sdi;
    logic        r_ldac_n;

    state_t      w_state_nxt;
    logic [7:0]  w_div_nxt;
    logic [4:0]  w_bits_nxt;
    logic [15:0] w_shift_nxt;
    logic        w_done_nxt;
    logic        w_ovr_nxt;
    logic        w_tc;
    logic        w_frame_active;
    logic [15:0] w_frame;

    assign w_frame = {1'b0, CFG_BUF, CFG_GA_N, CFG_SHDN_N, inSample ^ 12'h800};
    assign w_tc    = (r_div == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;
        // Every non-idle phase lasts exactly one SCK half-period.
        if (r_state != IDLE) begin
            w_div_nxt = w_tc ? 8'd0 : r_div + 8'd1;
            w_ovr_nxt = inSampleStrobe;
        end
        case (r_state)
            IDLE: begin
                if (inSampleStrobe) begin
                    w_shift_nxt = w_frame;
                    w_bits_nxt  = 5'd0;
                    w_div_nxt   = 8'd0;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_tc) begin
                    w_state_nxt = SHIFT_HI;
                    w_bits_nxt  = r_bits + 5'd1;
                end
            end
            SHIFT_HI: begin
                if (w_tc) begin
                    w_state_nxt = SHIFT_LO;
                    w_shift_nxt = {r_shift[14:0], 1'b0};
                end
            end
            SHIFT_LO: begin
                // The last low phase gives SDI hold time before CS rises.
                if (w_tc) begin
                    if (r_bits == 5'd16) begin
                        w_state_nxt = CS_END;
                    end else begin
                        w_state_nxt = SHIFT_HI;
                        w_bits_nxt  = r_bits + 5'd1;
                    end
                end
            end
            CS_END: begin
                if (w_tc) w_state_nxt = LDAC;
            end
            LDAC: begin
                if (w_tc) begin
                    w_state_nxt = IDLE;
                    w_bits_nxt  = 5'd0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_frame_active = (w_state_nxt == LOAD) || (w_state_nxt == SHIFT_HI) ||
                            (w_state_nxt == SHIFT_LO);

    // Pin-facing outputs are registered from the next state so the DAC sees no decode glitches.
    always_ff @(posedge inCLK) begin
        if (!inRST_N) begin
            r_state   <= IDLE;
            r_div     <= 8'd0;
            r_bits    <= 5'd0;
            r_shift   <= 16'd0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_sck     <= 1'b0;
            r_sdi     <= 1'b0;
            r_ldac_n  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bits    <= w_bits_nxt;
            r_shift   <= w_shift_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_ovr_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_cs_n    <= !w_frame_active;
            r_sck     <= (w_state_nxt == SHIFT_HI);
            r_sdi     <= w_frame_active & w_shift_nxt[15];
            r_ldac_n  <= (w_state_nxt != LDAC);
        end
    end

    assign outBusy     = r_busy;
    assign outDone     = r_done;
    assign outOverrun  = r_overrun;
    assign outCS_n     = r_cs_n;
    assign outSCK      = r_sck;
    assign outSDI      = r_sdi;
    assign outLDAC_n   = r_ldac_n;
    assign outDbgState = r_state;

endmodule

// File: tb/tb_sample_dac_spi.sv
// Bench for sample_dac_spi: two instances (CLK_DIV=4 and CLK_DIV=1) against a
// cycle-timeline reference model derived from the frame phase arithmetic.
module tb_sample_dac_spi;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        strb  [2];
    logic [11:0] smp   [2];
    logic        busy  [2];
    logic        done  [2];
    logic        ovr   [2];
    logic        cs_n  [2];
    logic        sck   [2];
    logic        sdi   [2];
    logic        ldac_n[2];
    logic [2:0]  dbg   [2];
    int          rise_cnt [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input int g, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s[u%0d] @%0t: got %0h expected %0h", tag, g, $time, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_frame(input logic [11:0] s);
        int v;
        v = int'($signed(s)) + 2048;
        return {4'h3, v[11:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int D  = (g == 0) ? 4 : 1;
        localparam int FR = 35 * D;

        sample_dac_spi #(.CLK_DIV(D)) dut (
            .inCLK(clk), .inRST_N(rst_n[g]), .inSample(smp[g]),
            .inSampleStrobe(strb[g]), .outBusy(busy[g]), .outDone(done[g]),
            .outOverrun(ovr[g]), .outCS_n(cs_n[g]), .outSCK(sck[g]),
            .outSDI(sdi[g]), .outLDAC_n(ldac_n[g]), .outDbgState(dbg[g])
        );

        // Reference model: frame timeline is 35 half-periods measured from the accept edge.
        int          cyc = 0;
        int          last = 0;
        bit          active = 0;
        bit          done_exp = 0;
        bit          ovr_exp = 0;
        logic [15:0] cur = 16'd0;
        logic [15:0] exp_q[$];

        always @(posedge clk) begin
            int  el;
            bit  busy_before;
            cyc++;
            el = cyc - last;
            done_exp = 1'b0;
            ovr_exp  = 1'b0;
            if (!rst_n[g]) begin
                if (active) exp_q.delete();
                active = 1'b0;
            end else begin
                busy_before = active && (el <= FR);
                done_exp    = active && (el == FR);
                if (active && el >= FR) active = 1'b0;
                if (strb[g]) begin
                    if (busy_before) begin
                        ovr_exp = 1'b1;
                    end else begin
                        active = 1'b1;
                        last   = cyc;
                        cur    = exp_frame(smp[g]);
                        exp_q.push_back(cur);
                    end
                end
            end
        end

        logic        prev_sck = 1'b0;
        logic [15:0] rx = 16'd0;
        int          busy_cnt = 0;
        int          ldac_cnt = 0;

        always @(negedge clk) begin
            int p;
            logic e_cs_n, e_sck, e_ldac_n, e_sdi;
            if (cyc > 0) begin
                e_cs_n = 1'b1; e_sck = 1'b0; e_ldac_n = 1'b1; e_sdi = 1'b0;
                if (active) begin
                    p        = (cyc - last) / D;
                    e_cs_n   = (p > 32);
                    e_sck    = (p >= 1) && (p <= 32) && (p % 2 == 1);
                    e_ldac_n = (p != 34);
                    e_sdi    = (p < 32) ? cur[15 - p / 2] : 1'b0;
                end
                check("busy",   g, busy[g],   active);
                check("done",   g, done[g],   done_exp);
                check("ovr",    g, ovr[g],    ovr_exp);
                check("cs_n",   g, cs_n[g],   e_cs_n);
                check("sck",    g, sck[g],    e_sck);
                check("sdi",    g, sdi[g],    e_sdi);
                check("ldac_n", g, ldac_n[g], e_ldac_n);

                if (sck[g] && !prev_sck) begin
                    rx = {rx[14:0], sdi[g]};
                    rise_cnt[g]++;
                end
                if (busy[g]) busy_cnt++;
                if (!ldac_n[g]) ldac_cnt++;
                if (done[g]) begin
                    check("frame_pending", g, exp_q.size(), 1);
                    if (exp_q.size() > 0) check("frame", g, rx, exp_q.pop_front());
                    check("sck_rises", g, rise_cnt[g], 16);
                    check("busy_len",  g, busy_cnt, FR);
                    check("ldac_len",  g, ldac_cnt, D);
                end
                if (!busy[g]) begin
                    rx = 16'd0; rise_cnt[g] = 0; busy_cnt = 0; ldac_cnt = 0;
                end
            end
            prev_sck = sck[g];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_now(input int g, input logic [11:0] s);
        strb[g] = 1'b1;
        smp[g]  = s;
        @(negedge clk);
        strb[g] = 1'b0;
        smp[g]  = 12'($urandom);
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[g] && n < budget);
        check("done_seen", g, done[g], 1'b1);
    endtask

    task automatic wait_rises(input int g, input int k, input int budget);
        int n = 0;
        while (rise_cnt[g] < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rise_reached", g, (rise_cnt[g] >= k), 1'b1);
    endtask

    task automatic send_and_wait(input int g, input logic [11:0] s, input int d);
        strobe_now(g, s);
        wait_done(g, 40 * d);
        idle($urandom_range(1, 5));
    endtask

    task automatic run_seq(input int g, input int d);
        logic [11:0] dir [4];
        dir[0] = 12'h000; dir[1] = 12'h7FF; dir[2] = 12'h801; dir[3] = 12'h800;
        for (int i = 0; i < 4; i++) send_and_wait(g, dir[i], d);
        send_and_wait(g, 12'hFFF, d);
        // Strobe mid-frame is dropped and flagged.
        strobe_now(g, 12'($urandom));
        idle(12 * d);
        strobe_now(g, 12'h123);
        wait_done(g, 40 * d);
        idle(40 * d);
        // Back-to-back frames: strobe in the outDone cycle.
        strobe_now(g, 12'($urandom));
        wait_done(g, 40 * d);
        strobe_now(g, 12'($urandom));
        wait_done(g, 40 * d);
        idle(3);
        // Random traffic with gaps that sometimes overlap a frame.
        for (int i = 0; i < 10; i++) begin
            strobe_now(g, 12'($urandom));
            idle($urandom_range(1, 40 * d));
        end
        idle(40 * d);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0; strb[g] = 1'b0; smp[g] = 12'h000; rise_cnt[g] = 0;
        end
        idle(3);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        idle(2);
        fork
            begin
                run_seq(0, 4);
                // Reset mid-frame after the 5th rising SCK edge.
                strobe_now(0, 12'($urandom));
                wait_rises(0, 5, 200);
                rst_n[0] = 1'b0;
                @(negedge clk);
                rst_n[0] = 1'b1;
                idle(200);
                send_and_wait(0, 12'h5A3, 4);
            end
            run_seq(1, 1);
        join
        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
